// File: rtl/register_file_mp.sv
// Multi-port register file: three combinational read ports, two prioritised
// synchronous write ports, optional zero register, write-through bypass and pending scoreboard.
module register_file_mp #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter bit ZERO_REG   = 1'b1,
  parameter bit BYPASS     = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] rd_addr_a,
  input  logic [ADDR_WIDTH-1:0] rd_addr_b,
  input  logic [ADDR_WIDTH-1:0] rd_addr_c,
  output logic [DATA_WIDTH-1:0] rd_data_a,
  output logic [DATA_WIDTH-1:0] rd_data_b,
  output logic [DATA_WIDTH-1:0] rd_data_c,
  output logic                  rd_pend_a,
  output logic                  rd_pend_b,
  output logic                  rd_pend_c,
  input  logic                  wr_en0,
  input  logic [ADDR_WIDTH-1:0] wr_addr0,
  input  logic [DATA_WIDTH-1:0] wr_data0,
  input  logic                  wr_en1,
  input  logic [ADDR_WIDTH-1:0] wr_addr1,
  input  logic [DATA_WIDTH-1:0] wr_data1,
  input  logic                  rsv_en,
  input  logic [ADDR_WIDTH-1:0] rsv_addr
);

  localparam int DEPTH = 2**ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs_q [DEPTH];
  logic [DATA_WIDTH-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0]      pend_q;
  logic [DEPTH-1:0]      pend_d;

  logic wr_ok0, wr_ok1, rsv_ok;

  assign wr_ok0 = wr_en0 && !(ZERO_REG && wr_addr0 == '0);
  assign wr_ok1 = wr_en1 && !(ZERO_REG && wr_addr1 == '0);
  assign rsv_ok = rsv_en && !(ZERO_REG && rsv_addr == '0);

  // Port 1 is applied after port 0 so it wins a collision; the reserve is
  // applied last so it wins over a same-address write clearing pend.
  always_comb begin
    // NOTE: defaults first so every path assigns regs_d/pend_d and no latch is inferred.
    regs_d = regs_q;
    pend_d = pend_q;
    if (wr_ok0) begin
      regs_d[wr_addr0] = wr_data0;
      pend_d[wr_addr0] = 1'b0;
    end
    if (wr_ok1) begin
      regs_d[wr_addr1] = wr_data1;
      pend_d[wr_addr1] = 1'b0;
    end
    if (rsv_ok) begin
      pend_d[rsv_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: this array is built from flops, not a RAM macro, so the asynchronous clear must reach every entry.
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
      pend_q <= '0;
    end else begin
      regs_q <= regs_d;
      pend_q <= pend_d;
    end
  end

  logic [ADDR_WIDTH-1:0] rd_addr [3];
  logic [DATA_WIDTH-1:0] rd_data [3];
  logic                  rd_pend [3];

  assign rd_addr[0] = rd_addr_a;
  assign rd_addr[1] = rd_addr_b;
  assign rd_addr[2] = rd_addr_c;

  // Bypass is gated by rst_n so held reset forces all reads to zero.
  always_comb begin
    for (int p = 0; p < 3; p++) begin
      rd_data[p] = regs_q[rd_addr[p]];
      rd_pend[p] = pend_q[rd_addr[p]];
      if (BYPASS && rst_n) begin
        if (wr_en0 && wr_addr0 == rd_addr[p]) begin
          rd_data[p] = wr_data0;
          rd_pend[p] = 1'b0;
        end
        if (wr_en1 && wr_addr1 == rd_addr[p]) begin
          rd_data[p] = wr_data1;
          rd_pend[p] = 1'b0;
        end
      end
      if (ZERO_REG && rd_addr[p] == '0) begin
        rd_data[p] = '0;
        rd_pend[p] = 1'b0;
      end
    end
  end

  assign rd_data_a = rd_data[0];
  assign rd_data_b = rd_data[1];
  assign rd_data_c = rd_data[2];
  assign rd_pend_a = rd_pend[0];
  assign rd_pend_b = rd_pend[1];
  assign rd_pend_c = rd_pend[2];

endmodule

// File: tb/tb_register_file_mp.sv
// Self-checking bench for register_file_mp: directed cases on two 32x32 instances
// and a random sweep on four 8x8 instances covering all ZERO_REG/BYPASS combinations.
module tb_register_file_mp;

  typedef struct packed {
    logic [4:0]  ra_a;
    logic [4:0]  ra_b;
    logic [4:0]  ra_c;
    logic        we0;
    logic [4:0]  wa0;
    logic [31:0] wd0;
    logic        we1;
    logic [4:0]  wa1;
    logic [31:0] wd1;
    logic        rsv_en;
    logic [4:0]  rsv_addr;
  } stim_t;

  typedef struct {
    string       tag;
    int          k;
    int          port;
    bit          is_pend;
    logic [31:0] exp;
  } sb_entry_t;

  logic  clk;
  logic  rst_n;
  stim_t sf;  // drives the two full-size instances (k = 0, 1)
  stim_t ss;  // drives the four small instances (k = 2..5)

  logic [31:0] rdd [6][3];
  logic        rdp [6][3];

  logic [31:0] mregs [6][32];
  bit          mpend [6][32];
  sb_entry_t   sb [$];

  int n_checks = 0;
  int n_err    = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // k=0: ZERO_REG=1 BYPASS=1
  register_file_mp u_full_zb (
    .clk(clk), .rst_n(rst_n),
    .rd_addr_a(sf.ra_a), .rd_addr_b(sf.ra_b), .rd_addr_c(sf.ra_c),
    .rd_data_a(rdd[0][0]), .rd_data_b(rdd[0][1]), .rd_data_c(rdd[0][2]),
    .rd_pend_a(rdp[0][0]), .rd_pend_b(rdp[0][1]), .rd_pend_c(rdp[0][2]),
    .wr_en0(sf.we0), .wr_addr0(sf.wa0), .wr_data0(sf.wd0),
    .wr_en1(sf.we1), .wr_addr1(sf.wa1), .wr_data1(sf.wd1),
    .rsv_en(sf.rsv_en), .rsv_addr(sf.rsv_addr)
  );

  // k=1: ZERO_REG=0 BYPASS=0
  register_file_mp #(.ZERO_REG(1'b0), .BYPASS(1'b0)) u_full_plain (
    .clk(clk), .rst_n(rst_n),
    .rd_addr_a(sf.ra_a), .rd_addr_b(sf.ra_b), .rd_addr_c(sf.ra_c),
    .rd_data_a(rdd[1][0]), .rd_data_b(rdd[1][1]), .rd_data_c(rdd[1][2]),
    .rd_pend_a(rdp[1][0]), .rd_pend_b(rdp[1][1]), .rd_pend_c(rdp[1][2]),
    .wr_en0(sf.we0), .wr_addr0(sf.wa0), .wr_data0(sf.wd0),
    .wr_en1(sf.we1), .wr_addr1(sf.wa1), .wr_data1(sf.wd1),
    .rsv_en(sf.rsv_en), .rsv_addr(sf.rsv_addr)
  );

  // k = g+2: ZERO_REG = g/2, BYPASS = g%2
  for (genvar g = 0; g < 4; g++) begin : g_small
    logic [7:0] da, db, dc;
    logic       pa, pb, pc;
    register_file_mp #(
      .DATA_WIDTH(8), .ADDR_WIDTH(3),
      .ZERO_REG((g / 2) != 0), .BYPASS((g % 2) != 0)
    ) u_small (
      .clk(clk), .rst_n(rst_n),
      .rd_addr_a(ss.ra_a[2:0]), .rd_addr_b(ss.ra_b[2:0]), .rd_addr_c(ss.ra_c[2:0]),
      .rd_data_a(da), .rd_data_b(db), .rd_data_c(dc),
      .rd_pend_a(pa), .rd_pend_b(pb), .rd_pend_c(pc),
      .wr_en0(ss.we0), .wr_addr0(ss.wa0[2:0]), .wr_data0(ss.wd0[7:0]),
      .wr_en1(ss.we1), .wr_addr1(ss.wa1[2:0]), .wr_data1(ss.wd1[7:0]),
      .rsv_en(ss.rsv_en), .rsv_addr(ss.rsv_addr[2:0])
    );
    assign rdd[g+2][0] = 32'(da);
    assign rdd[g+2][1] = 32'(db);
    assign rdd[g+2][2] = 32'(dc);
    assign rdp[g+2][0] = pa;
    assign rdp[g+2][1] = pb;
    assign rdp[g+2][2] = pc;
  end

  function automatic bit zero_of(int k);
    if (k == 0) return 1'b1;
    if (k == 1) return 1'b0;
    return ((k - 2) / 2) != 0;
  endfunction

  function automatic bit byp_of(int k);
    if (k == 0) return 1'b1;
    if (k == 1) return 1'b0;
    return ((k - 2) % 2) != 0;
  endfunction

  function automatic stim_t stim_of(int k);
    return (k < 2) ? sf : ss;
  endfunction

  function automatic logic [4:0] addr_of(stim_t s, int p);
    return (p == 0) ? s.ra_a : (p == 1) ? s.ra_b : s.ra_c;
  endfunction

  function automatic logic [31:0] exp_data(int k, logic [4:0] a, stim_t s);
    if (zero_of(k) && a == 5'd0) return 32'd0;
    if (byp_of(k) && rst_n) begin
      if (s.we1 && s.wa1 == a) return s.wd1;
      if (s.we0 && s.wa0 == a) return s.wd0;
    end
    return mregs[k][a];
  endfunction

  function automatic bit exp_pend(int k, logic [4:0] a, stim_t s);
    if (zero_of(k) && a == 5'd0) return 1'b0;
    if (byp_of(k) && rst_n && ((s.we1 && s.wa1 == a) || (s.we0 && s.wa0 == a))) return 1'b0;
    return mpend[k][a];
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 6; k++)
      for (int a = 0; a < 32; a++) begin
        mregs[k][a] = 32'd0;
        mpend[k][a] = 1'b0;
      end
  endtask

  task automatic model_edge();
    stim_t s;
    if (!rst_n) return;
    for (int k = 0; k < 6; k++) begin
      s = stim_of(k);
      if (s.we0 && !(zero_of(k) && s.wa0 == 5'd0)) begin
        mregs[k][s.wa0] = s.wd0;
        mpend[k][s.wa0] = 1'b0;
      end
      if (s.we1 && !(zero_of(k) && s.wa1 == 5'd0)) begin
        mregs[k][s.wa1] = s.wd1;
        mpend[k][s.wa1] = 1'b0;
      end
      if (s.rsv_en && !(zero_of(k) && s.rsv_addr == 5'd0)) mpend[k][s.rsv_addr] = 1'b1;
    end
  endtask

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Push model expectations for every port of every instance, compare, then clock the model.
  task automatic tick(string tag);
    sb_entry_t e;
    stim_t     s;
    for (int k = 0; k < 6; k++) begin
      s = stim_of(k);
      for (int p = 0; p < 3; p++) begin
        sb.push_back('{tag, k, p, 1'b0, exp_data(k, addr_of(s, p), s)});
        sb.push_back('{tag, k, p, 1'b1, 32'(exp_pend(k, addr_of(s, p), s))});
      end
    end
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.is_pend)
        check($sformatf("%s_k%0d_p%0d_pend", e.tag, e.k, e.port), 32'(rdp[e.k][e.port]), e.exp);
      else
        check($sformatf("%s_k%0d_p%0d_data", e.tag, e.k, e.port), rdd[e.k][e.port], e.exp);
    end
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    sf    = '0;
    ss    = '0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Reset mid-cycle clears previously written data immediately.
    sf = '0; sf.we0 = 1'b1; sf.wa0 = 5'd2; sf.wd0 = 32'hFFFF_FFFF;
    tick("wr_r2");
    sf = '0; sf.ra_a = 5'd2;
    #1;
    check("pre_reset_r2_k0", rdd[0][0], 32'hFFFF_FFFF);
    check("pre_reset_r2_k1", rdd[1][0], 32'hFFFF_FFFF);
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("reset_r2_k0", rdd[0][0], 32'd0);
    check("reset_r2_k1", rdd[1][0], 32'd0);
    for (int p = 0; p < 3; p++) begin
      check($sformatf("reset_pend_k0_p%0d", p), 32'(rdp[0][p]), 32'd0);
      check($sformatf("reset_pend_k1_p%0d", p), 32'(rdp[1][p]), 32'd0);
    end
    tick("reset_held");
    rst_n = 1'b1;

    sf = '0; sf.we0 = 1'b1; sf.wa0 = 5'd3; sf.wd0 = 32'hA;
    tick("wr_r3");
    sf = '0; sf.ra_a = 5'd3;
    #1;
    check("r3_k0", rdd[0][0], 32'hA);
    check("r3_k1", rdd[1][0], 32'hA);
    tick("rd_r3");

    // Dual write to distinct addresses, then a same-address collision.
    sf = '0; sf.we0 = 1'b1; sf.wa0 = 5'd4; sf.wd0 = 32'h11;
    sf.we1 = 1'b1; sf.wa1 = 5'd5; sf.wd1 = 32'h22;
    tick("dual_wr");
    sf = '0; sf.we0 = 1'b1; sf.wa0 = 5'd6; sf.wd0 = 32'h33;
    sf.we1 = 1'b1; sf.wa1 = 5'd6; sf.wd1 = 32'h44;
    tick("coll_wr");
    sf = '0; sf.ra_a = 5'd4; sf.ra_b = 5'd5; sf.ra_c = 5'd6;
    #1;
    check("dual_r4_k1", rdd[1][0], 32'h11);
    check("dual_r5_k1", rdd[1][1], 32'h22);
    check("coll_r6_k0", rdd[0][2], 32'h44);
    check("coll_r6_k1", rdd[1][2], 32'h44);
    tick("rd_dual");

    // Zero register: write and reserve of address 0.
    sf = '0; sf.we0 = 1'b1; sf.wa0 = 5'd0; sf.wd0 = 32'hDEAD;
    sf.rsv_en = 1'b1; sf.rsv_addr = 5'd0;
    #1;
    for (int p = 0; p < 3; p++) begin
      check($sformatf("zero_same_data_p%0d", p), rdd[0][p], 32'd0);
      check($sformatf("zero_same_pend_p%0d", p), 32'(rdp[0][p]), 32'd0);
    end
    tick("wr_zero");
    sf = '0;
    #1;
    for (int p = 0; p < 3; p++) begin
      check($sformatf("zero_next_data_p%0d", p), rdd[0][p], 32'd0);
      check($sformatf("zero_next_pend_p%0d", p), 32'(rdp[0][p]), 32'd0);
    end
    check("nozero_r0_data", rdd[1][0], 32'hDEAD);
    check("nozero_r0_pend", 32'(rdp[1][0]), 32'd1);
    tick("rd_zero");

    // Bypass versus registered read of reg 7.
    sf = '0; sf.ra_b = 5'd7; sf.we1 = 1'b1; sf.wa1 = 5'd7; sf.wd1 = 32'h77;
    #1;
    check("byp_same_k0", rdd[0][1], 32'h77);
    check("nobyp_same_k1", rdd[1][1], 32'd0);
    tick("wr_r7");
    sf = '0; sf.ra_b = 5'd7;
    #1;
    check("nobyp_next_k1", rdd[1][1], 32'h77);
    tick("rd_r7");

    // Pending scoreboard on reg 9.
    sf = '0; sf.ra_c = 5'd9; sf.rsv_en = 1'b1; sf.rsv_addr = 5'd9;
    #1;
    check("rsv_same_k0", 32'(rdp[0][2]), 32'd0);
    tick("rsv_r9");
    sf = '0; sf.ra_c = 5'd9;
    #1;
    check("rsv_next_k0", 32'(rdp[0][2]), 32'd1);
    check("rsv_next_k1", 32'(rdp[1][2]), 32'd1);
    sf.we0 = 1'b1; sf.wa0 = 5'd9; sf.wd0 = 32'h99;
    #1;
    check("clr_same_byp_k0", 32'(rdp[0][2]), 32'd0);
    check("clr_same_nobyp_k1", 32'(rdp[1][2]), 32'd1);
    tick("wr_r9");
    sf = '0; sf.ra_c = 5'd9;
    #1;
    check("clr_next_k1", 32'(rdp[1][2]), 32'd0);
    check("clr_next_data_k1", rdd[1][2], 32'h99);
    sf.we0 = 1'b1; sf.wa0 = 5'd9; sf.wd0 = 32'h5A5A;
    sf.rsv_en = 1'b1; sf.rsv_addr = 5'd9;
    tick("rsv_wr_r9");
    sf = '0; sf.ra_c = 5'd9;
    #1;
    check("rsvwr_pend_k0", 32'(rdp[0][2]), 32'd1);
    check("rsvwr_pend_k1", 32'(rdp[1][2]), 32'd1);
    check("rsvwr_data_k0", rdd[0][2], 32'h5A5A);
    check("rsvwr_data_k1", rdd[1][2], 32'h5A5A);
    tick("rd_r9");

    // Random sweep on the small instances.
    sf = '0;
    for (int i = 0; i < 2000; i++) begin
      ss          = '0;
      ss.ra_a     = 5'($urandom_range(0, 7));
      ss.ra_b     = 5'($urandom_range(0, 7));
      ss.ra_c     = 5'($urandom_range(0, 7));
      ss.we0      = 1'($urandom_range(0, 1));
      ss.wa0      = 5'($urandom_range(0, 7));
      ss.wd0      = 32'($urandom_range(0, 255));
      ss.we1      = 1'($urandom_range(0, 1));
      ss.wa1      = 5'($urandom_range(0, 7));
      ss.wd1      = 32'($urandom_range(0, 255));
      ss.rsv_en   = ($urandom_range(0, 2) == 0);
      ss.rsv_addr = 5'($urandom_range(0, 7));
      tick("rand");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
